// File: rtl/skid_reg.sv
// skid_reg: two-entry elastic holding register (skid buffer) with a
// valid/ready handshake on both sides. in_ready, out_valid, out_data and
// count all come straight from flops, so a downstream stall never forms a
// combinational path back to the upstream stage.
module skid_reg #(
   parameter int              WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   // Occupancy state: EMPTY (nothing held), ONE (main valid),
   // FULL (main and skid valid). "Skid valid, main invalid" has no encoding.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_main_data;
   logic [WIDTH-1:0] r_skid_data;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;

   logic             r_in_ready;
   logic             r_out_valid;
   logic [1:0]       r_count;
   logic             w_in_ready_nxt;
   logic             w_out_valid_nxt;
   logic [1:0]       w_count_nxt;

   logic             w_in_fire;
   logic             w_out_fire;

   // Handshakes use the registered ready/valid the partner actually sees.
   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // State, storage and registered outputs; async reset to the empty state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_main_data <= RESET_VAL;
         r_skid_data <= RESET_VAL;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_main_data <= w_main_nxt;
         r_skid_data <= w_skid_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_count     <= w_count_nxt;
      end
   end

   // Next state and next storage contents; flush wins over any handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main_data;
      w_skid_nxt  = r_skid_data;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = RESET_VAL;
         w_skid_nxt  = RESET_VAL;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_main_nxt  = in_data;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  // Head leaves while the new beat takes its place.
                  w_main_nxt  = in_data;
                  w_state_nxt = ST_ONE;
               end else if (w_in_fire) begin
                  // Downstream stalled: park the beat behind the head.
                  w_skid_nxt  = in_data;
                  w_state_nxt = ST_FULL;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end else begin
                  w_state_nxt = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the output side can move.
               if (w_out_fire) begin
                  w_main_nxt  = r_skid_data;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_FULL;
               end
            end
            default: begin
               // Unused encoding: recover to a clean empty buffer.
               w_state_nxt = ST_EMPTY;
               w_main_nxt  = RESET_VAL;
               w_skid_nxt  = RESET_VAL;
            end
         endcase
      end
   end

   // Decode the next state into the values loaded into the output flops.
   always_comb begin
      w_in_ready_nxt  = 1'b1;
      w_out_valid_nxt = 1'b0;
      w_count_nxt     = 2'd0;
      case (w_state_nxt)
         ST_EMPTY: begin
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b0;
            w_count_nxt     = 2'd0;
         end
         ST_ONE: begin
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b1;
            w_count_nxt     = 2'd1;
         end
         ST_FULL: begin
            w_in_ready_nxt  = 1'b0;
            w_out_valid_nxt = 1'b1;
            w_count_nxt     = 2'd2;
         end
         default: begin
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b0;
            w_count_nxt     = 2'd0;
         end
      endcase
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main_data;
   assign count     = r_count;

endmodule
